// File: rtl/isa_types.sv
// Shared ISA-level types: machine word width, store widths and the
// memory-arbiter state/owner encodings used by the hart memory path.
package isa_types;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        write_byte = 2'd0,
        write_half = 2'd1,
        write_word = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        owner_fetch = 1'b0,
        owner_data  = 1'b1
    } mem_arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection between the fetch and load/store requesters.
// Build option MEM_ARB_ROUND_ROBIN_EN: when defined, ties go to the port
// not granted last; otherwise data always beats fetch on a tie.
module mem_arb_select
    import isa_types::*;
(
    input  logic           fetch_req,
    input  logic           data_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  mem_arb_owner_t last_grant,
`endif
    output logic           grant_fetch,
    output logic           grant_data
);

    // One-hot grant from the request pair; at most one grant is ever high.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (fetch_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_grant == owner_data) begin
                grant_fetch = 1'b1;
            end else begin
                grant_data = 1'b1;
            end
`else
            grant_data = 1'b1;
`endif
        end else if (data_req) begin
            grant_data = 1'b1;
        end else if (fetch_req) begin
            grant_fetch = 1'b1;
        end else begin
            grant_fetch = 1'b0;
            grant_data  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One request is latched at a time and walked through ADDR, DATA and RESP
// phases, so each access occupies four cycles including the accept cycle.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (a last_grant flop exists only in that build); default is data-first.
module mem_arbiter
    import isa_types::*;
#(
    parameter int XLEN = isa_types::XLEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [XLEN-1:0]   fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_rvalid,
    output logic [XLEN-1:0]   fetch_rdata,
    input  logic              data_req,
    input  logic [XLEN-1:0]   data_addr,
    input  logic              data_wenable,
    input  write_width_t      data_wwidth,
    input  logic [XLEN-1:0]   data_wdata,
    output logic              data_ready,
    output logic              data_rvalid,
    output logic [XLEN-1:0]   data_rdata,
    output logic [XLEN-1:0]   mem_addr,
    output write_width_t      mem_wwidth,
    output logic              mem_wenable,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    mem_arb_state_t state_r;
    mem_arb_state_t state_s;
    logic [XLEN-1:0] addr_r;
    logic            wenable_r;
    write_width_t    wwidth_r;
    logic [XLEN-1:0] wdata_r;
    mem_arb_owner_t  owner_r;
    logic [XLEN-1:0] rdata_r;
    logic            grant_fetch_s;
    logic            grant_data_s;
    logic            busy_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_arb_owner_t  last_grant_r;
`endif

    mem_arb_select u_select (
        .fetch_req   (fetch_req),
        .data_req    (data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_r),
`endif
        .grant_fetch (grant_fetch_s),
        .grant_data  (grant_data_s)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and ready generation; ready is only possible while idle.
    always_comb begin
        state_s     = state_r;
        fetch_ready = 1'b0;
        data_ready  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_fetch_s) begin
                    fetch_ready = 1'b1;
                    state_s     = ADDR;
                end else if (grant_data_s) begin
                    data_ready = 1'b1;
                    state_s    = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR:    state_s = DATA;
            DATA:    state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Latch the accepted request; fetches become aligned word reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r    <= {XLEN{1'b0}};
            wenable_r <= 1'b0;
            wwidth_r  <= write_word;
            wdata_r   <= {XLEN{1'b0}};
            owner_r   <= owner_fetch;
        end else if (fetch_ready) begin
            addr_r    <= {fetch_addr[XLEN-1:2], 2'b00};
            wenable_r <= 1'b0;
            wwidth_r  <= write_word;
            wdata_r   <= {XLEN{1'b0}};
            owner_r   <= owner_fetch;
        end else if (data_ready) begin
            addr_r    <= data_addr;
            wenable_r <= data_wenable;
            wwidth_r  <= data_wwidth;
            wdata_r   <= data_wdata;
            owner_r   <= owner_data;
        end else begin
            addr_r    <= addr_r;
            wenable_r <= wenable_r;
            wwidth_r  <= wwidth_r;
            wdata_r   <= wdata_r;
            owner_r   <= owner_r;
        end
    end

    // Capture read data at the end of the DATA phase; stores return zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_r <= {XLEN{1'b0}};
        end else if (state_r == DATA) begin
            rdata_r <= wenable_r ? {XLEN{1'b0}} : mem_rdata;
        end else begin
            rdata_r <= rdata_r;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember which port won the most recent acceptance for tie breaking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_r <= owner_data;
        end else if (fetch_ready) begin
            last_grant_r <= owner_fetch;
        end else if (data_ready) begin
            last_grant_r <= owner_data;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Memory port drive: latched request during ADDR/DATA, quiet otherwise.
    always_comb begin
        busy_s      = (state_r == ADDR) || (state_r == DATA);
        mem_addr    = {XLEN{1'b0}};
        mem_wwidth  = write_word;
        mem_wdata   = {XLEN{1'b0}};
        mem_wenable = 1'b0;
        if (busy_s) begin
            mem_addr    = addr_r;
            mem_wwidth  = wwidth_r;
            mem_wdata   = wdata_r;
            mem_wenable = wenable_r && (state_r == ADDR);
        end else begin
            mem_wenable = 1'b0;
        end
    end

    // Response pulse to the owner; read data is zero whenever rvalid is low.
    always_comb begin
        fetch_rvalid = (state_r == RESP) && (owner_r == owner_fetch);
        data_rvalid  = (state_r == RESP) && (owner_r == owner_data);
        fetch_rdata  = {XLEN{1'b0}};
        data_rdata   = {XLEN{1'b0}};
        if (fetch_rvalid) begin
            fetch_rdata = rdata_r;
        end else if (data_rvalid) begin
            data_rdata = rdata_r;
        end else begin
            fetch_rdata = {XLEN{1'b0}};
            data_rdata  = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    import isa_types::*;

    logic         clock;
    logic         reset;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         fetch_ready;
    logic         fetch_rvalid;
    logic [31:0]  fetch_rdata;
    logic         data_req;
    logic [31:0]  data_addr;
    logic         data_wenable;
    write_width_t data_wwidth;
    logic [31:0]  data_wdata;
    logic         data_ready;
    logic         data_rvalid;
    logic [31:0]  data_rdata;
    logic [31:0]  mem_addr;
    write_width_t mem_wwidth;
    logic         mem_wenable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_wenable(data_wenable),
        .data_wwidth(data_wwidth), .data_wdata(data_wdata), .data_ready(data_ready),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_addr(mem_addr), .mem_wwidth(mem_wwidth), .mem_wenable(mem_wenable),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Merge a store of the given width into a memory word (byte lanes by addr).
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input write_width_t w, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (w)
            write_byte: r[a[1:0]*8 +: 8] = d[7:0];
            write_half: r[a[1]*16 +: 16] = d[15:0];
            default:    r = d;
        endcase
        return r;
    endfunction

    // Environment memory seen by the DUT, and the model's own copy.
    logic [31:0] env_mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    assign mem_rdata = env_mem[mem_addr[12:2]];

    // Memory write edge driven by the DUT's write enable.
    always @(posedge clock) begin
        if (mem_wenable) env_mem[mem_addr[12:2]] <= merge(env_mem[mem_addr[12:2]], mem_addr, mem_wwidth, mem_wdata);
    end

    typedef struct {
        logic         is_fetch;
        logic         store;
        logic [31:0]  addr;
        write_width_t width;
        logic [31:0]  wdata;
        logic [31:0]  rdata;
    } txn_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   age      = 0;     // cycles since acceptance of the current access
    txn_t cur;
    logic last_was_data = 1'b1;
    logic auto_drop     = 1'b1;

    logic         obs_fready, obs_dready, obs_wen, obs_fv, obs_dv;
    logic [31:0]  obs_addr, obs_wdata, obs_frd, obs_drd;
    write_width_t obs_wwidth;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: compare all outputs to the model at negedge, then
    // advance the model past the next rising edge.
    task automatic cycle();
        logic wf, wd;
        logic [31:0] e_addr, e_wdata, e_frd, e_drd;
        logic e_wen, e_fv, e_dv;
        write_width_t e_ww;
        @(negedge clock);
        wf = 1'b0; wd = 1'b0;
        e_addr = 32'd0; e_wdata = 32'd0; e_wen = 1'b0; e_ww = write_word;
        e_fv = 1'b0; e_dv = 1'b0; e_frd = 32'd0; e_drd = 32'd0;
        if (age == 0) begin
            if (fetch_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (last_was_data) wf = 1'b1; else wd = 1'b1;
`else
                wd = 1'b1;
`endif
            end else begin
                wf = fetch_req;
                wd = data_req;
            end
        end else if (age == 1 || age == 2) begin
            e_addr = cur.addr; e_wdata = cur.wdata; e_ww = cur.width;
            e_wen = cur.store && (age == 1);
        end else begin
            e_fv = cur.is_fetch;  e_dv = !cur.is_fetch;
            e_frd = cur.is_fetch ? cur.rdata : 32'd0;
            e_drd = cur.is_fetch ? 32'd0 : cur.rdata;
        end
        obs_fready = fetch_ready; obs_dready = data_ready; obs_addr = mem_addr;
        obs_wen = mem_wenable; obs_wwidth = mem_wwidth; obs_wdata = mem_wdata;
        obs_fv = fetch_rvalid; obs_dv = data_rvalid; obs_frd = fetch_rdata; obs_drd = data_rdata;
        chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, wf});
        chk("data_ready", {31'd0, data_ready}, {31'd0, wd});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wenable", {31'd0, mem_wenable}, {31'd0, e_wen});
        chk("mem_wwidth", {30'd0, mem_wwidth}, {30'd0, e_ww});
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("fetch_rvalid", {31'd0, fetch_rvalid}, {31'd0, e_fv});
        chk("data_rvalid", {31'd0, data_rvalid}, {31'd0, e_dv});
        chk("fetch_rdata", fetch_rdata, e_frd);
        chk("data_rdata", data_rdata, e_drd);
        @(posedge clock);
        #1;
        if (age == 0) begin
            if (wf || wd) begin
                cur.is_fetch = wf;
                if (wf) begin
                    cur.addr = {fetch_addr[31:2], 2'b00}; cur.store = 1'b0;
                    cur.width = write_word; cur.wdata = 32'd0;
                    if (auto_drop) fetch_req = 1'b0;
                end else begin
                    cur.addr = data_addr; cur.store = data_wenable;
                    cur.width = data_wwidth; cur.wdata = data_wdata;
                    if (auto_drop) data_req = 1'b0;
                end
                last_was_data = wd;
                age = 1;
            end
        end else if (age == 1) begin
            if (cur.store) ref_mem[cur.addr[12:2]] = merge(ref_mem[cur.addr[12:2]], cur.addr, cur.width, cur.wdata);
            age = 2;
        end else if (age == 2) begin
            cur.rdata = cur.store ? 32'd0 : ref_mem[cur.addr[12:2]];
            age = 3;
        end else begin
            age = 0;
        end
    endtask

    typedef struct {
        logic         is_fetch;
        logic         wen;
        write_width_t width;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_wdata;
        logic [31:0]  exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, write_word, 32'h0006, 32'h0,        32'h0004, 32'h0,        32'h00500093};
        vecs[1] = '{1'b0, 1'b1, write_word, 32'h0800, 32'hDEADBEEF, 32'h0800, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, write_word, 32'h0800, 32'h0,        32'h0800, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, write_byte, 32'h1800, 32'h0000005A, 32'h1800, 32'h0000005A, 32'h0};
        vecs[4] = '{1'b0, 1'b0, write_word, 32'h1800, 32'h0,        32'h1800, 32'h0,        32'h0000005A};
        vecs[5] = '{1'b0, 1'b0, write_word, 32'h0900, 32'h0,        32'h0900, 32'h0,        32'h0};
        vecs[6] = '{1'b0, 1'b1, write_half, 32'h1802, 32'h00001234, 32'h1802, 32'h00001234, 32'h0};
        vecs[7] = '{1'b0, 1'b0, write_word, 32'h1800, 32'h0,        32'h1800, 32'h0,        32'h1234005A};

        for (int i = 0; i < 2048; i++) begin
            env_mem[i] = (i < 256) ? ((i * 32'h01010101) ^ 32'hA5A50000) : 32'd0;
        end
        env_mem[1] = 32'h00500093;
        for (int i = 0; i < 2048; i++) ref_mem[i] = env_mem[i];

        reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'd0; data_req = 1'b0;
        data_addr = 32'd0; data_wenable = 1'b0; data_wwidth = write_word; data_wdata = 32'd0;
        repeat (2) @(posedge clock);
        // Reset values
        @(negedge clock);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wenable", {31'd0, mem_wenable}, 32'd0);
        chk("rst_mem_wwidth", {30'd0, mem_wwidth}, {30'd0, write_word});
        chk("rst_rvalids", {30'd0, fetch_rvalid, data_rvalid}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // Reset pulsed during ADDR of a store aborts it
        data_req = 1'b1; data_addr = 32'h0900; data_wenable = 1'b1;
        data_wwidth = write_word; data_wdata = 32'h11112222;
        cycle();
        @(negedge clock);
        chk("abort_wen_before", {31'd0, mem_wenable}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_wen_drop", {31'd0, mem_wenable}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_rvalid", {31'd0, data_rvalid}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        age = 0; last_was_data = 1'b1; data_req = 1'b0;
        repeat (4) cycle();

        // Both requesters held continuously
        auto_drop = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0010;
        data_req = 1'b1; data_addr = 32'h0020; data_wenable = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 11) begin fetch_req = 1'b0; data_req = 1'b0; end
            cycle();
            if (k % 4 == 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                chk("rr_grant_fetch", {31'd0, obs_fready}, (k == 4) ? 32'd0 : 32'd1);
                chk("rr_grant_data", {31'd0, obs_dready}, (k == 4) ? 32'd1 : 32'd0);
`else
                chk("fix_grant_fetch", {31'd0, obs_fready}, 32'd0);
                chk("fix_grant_data", {31'd0, obs_dready}, 32'd1);
`endif
            end
        end
        auto_drop = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_fetch) begin
                fetch_req = 1'b1; fetch_addr = vecs[i].addr;
            end else begin
                data_req = 1'b1; data_addr = vecs[i].addr; data_wenable = vecs[i].wen;
                data_wwidth = vecs[i].width; data_wdata = vecs[i].wdata;
            end
            cycle();
            chk("tbl_ready", {31'd0, vecs[i].is_fetch ? obs_fready : obs_dready}, 32'd1);
            cycle();
            chk("tbl_addr_a", obs_addr, vecs[i].exp_addr);
            chk("tbl_wen_a", {31'd0, obs_wen}, {31'd0, vecs[i].wen});
            chk("tbl_wwidth", {30'd0, obs_wwidth}, {30'd0, vecs[i].width});
            chk("tbl_wdata", obs_wdata, vecs[i].exp_wdata);
            cycle();
            chk("tbl_addr_d", obs_addr, vecs[i].exp_addr);
            chk("tbl_wen_d", {31'd0, obs_wen}, 32'd0);
            cycle();
            chk("tbl_rvalid", {31'd0, vecs[i].is_fetch ? obs_fv : obs_dv}, 32'd1);
            chk("tbl_rdata", vecs[i].is_fetch ? obs_frd : obs_drd, vecs[i].exp_rdata);
        end

        // Data request raised two cycles into a fetch access
        fetch_req = 1'b1; fetch_addr = 32'h0040;
        cycle(); cycle();
        data_req = 1'b1; data_addr = 32'h0044; data_wenable = 1'b0;
        cycle(); chk("ovl_ready_n2", {31'd0, obs_dready}, 32'd0);
        cycle(); chk("ovl_ready_n3", {31'd0, obs_dready}, 32'd0);
        chk("ovl_fetch_rvalid", {31'd0, obs_fv}, 32'd1);
        cycle(); chk("ovl_ready_n4", {31'd0, obs_dready}, 32'd1);
        cycle(); cycle(); cycle();
        chk("ovl_data_rvalid", {31'd0, obs_dv}, 32'd1);
        chk("ovl_data_rdata", obs_drd, ref_mem[17]);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (!fetch_req && $urandom_range(0, 3) == 0) begin
                fetch_req = 1'b1;
                fetch_addr = ($urandom_range(0, 2047) << 2) | $urandom_range(0, 3);
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1'b1;
                data_addr = ($urandom_range(0, 2047) << 2) | $urandom_range(0, 3);
                data_wenable = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 2))
                    0:       data_wwidth = write_byte;
                    1:       data_wwidth = write_half;
                    default: data_wwidth = write_word;
                endcase
                data_wdata = $urandom;
            end
            cycle();
        end
        fetch_req = 1'b0; data_req = 1'b0;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `memory` port between the hart's instruction-fetch path and its load/store path. It accepts one request at a time over a req/ready handshake, latches it, and sequences the memory port through a fixed address/data phase. It then returns a registered response to the winning requester. Sits between the hart core and `memory`, and drives `memory`'s addr/wwidth/wenable/wdata directly.

## Interface
- `XLEN`, default from `isa_types`: address and data width (32).
- `clock  input  1  sole clock; all flops on posedge`
- `reset  input  1  asynchronous, active-high; clears all state`
- `fetch_req  input  1  fetch request; held stable until accepted`
- `fetch_addr  input  XLEN  fetch address; bits [1:0] ignored (forced 0)`
- `fetch_ready  output  1  fetch request accepted this cycle`
- `fetch_rvalid  output  1  one-cycle pulse: fetch_rdata valid`
- `fetch_rdata  output  XLEN  fetched word`
- `data_req  input  1  load/store request; held stable until accepted`
- `data_addr  input  XLEN  load/store address`
- `data_wenable  input  1  1 = store, 0 = load`
- `data_wwidth  input  write_width_t  store width`
- `data_wdata  input  XLEN  store data`
- `data_ready  output  1  data request accepted this cycle`
- `data_rvalid  output  1  one-cycle pulse: load data valid or store complete`
- `data_rdata  output  XLEN  load data; 0 for stores`
- `mem_addr  output  XLEN  to memory addr`
- `mem_wwidth  output  write_width_t  to memory wwidth`
- `mem_wenable  output  1  to memory wenable`
- `mem_wdata  output  XLEN  to memory wdata`
- `mem_rdata  input  XLEN  from memory rdata`

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Reset state is IDLE.
- IDLE
  - If any request is pending, arbitrate (see Configuration) and assert exactly one of `fetch_ready` / `data_ready` combinationally.
  - On that edge, latch the winner's addr/wenable/wwidth/wdata plus an owner bit, then go to ADDR.
  - With no request pending, stay in IDLE.
- ADDR
  - `mem_addr` is driven from the latched address.
  - `mem_wenable` is 1 only here and only for stores, giving exactly one write edge.
  - Go to DATA.
- DATA
  - `mem_addr` is held and `mem_wenable` is 0.
  - For loads/fetches, capture `mem_rdata` into `rdata_q` at the end of the cycle. For stores, `rdata_q` is 0.
  - Go to RESP.
- RESP
  - Assert the owner's `*_rvalid` for one cycle; `*_rdata` comes from `rdata_q`.
  - Return to IDLE.
  - Ready is never asserted in RESP.
- Fetch is always a word read: `mem_addr[1:0]` = 0, `mem_wenable` = 0, `mem_wwidth` = `write_word`.
- `mem_wwidth` and `mem_wdata` are passed from the latched request unchanged. Alignment and width legality belong to `memory`/`ram`.
- A requester whose req drops before ready is simply not serviced. Nothing is latched from the other port while busy.

## Timing
- Request accepted at edge N (ready=1 in cycle N):
  - ADDR in cycle N+1
  - DATA in cycle N+2
  - `rvalid` in cycle N+3
  - next possible ready in cycle N+4
- Throughput is one access per 4 cycles.
- Reset values:
  - `fetch_ready`, `data_ready`, `fetch_rvalid`, `data_rvalid`, `mem_wenable` = 0
  - `mem_addr`, `mem_wdata`, `fetch_rdata`, `data_rdata` = 0
  - `mem_wwidth` = `write_word`
- In IDLE, `mem_addr` = 0 and `mem_wenable` = 0.
- `*_rdata` is 0 whenever the matching `*_rvalid` is 0.
- Reset asserted mid-access aborts immediately and asynchronously:
  - `mem_wenable` drops at once.
  - No `rvalid` is issued for the aborted request.
  - The requester must reissue after reset.
- Simultaneous `fetch_req` and `data_req` in IDLE: only the winner sees ready. The loser keeps req high and is granted in its next IDLE cycle, subject to the arbitration policy.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A `last_grant` flop is updated on each acceptance; on a tie, the port not granted last wins.
  - `last_grant` resets to data, so fetch wins the first tie.
- Not defined: fixed priority, data over fetch. No `last_grant` flop exists.
- Single-requester behaviour is identical in both builds.

## Structure
- Shared package `isa_types`:
  - State enum `mem_arb_state_t` {IDLE, ADDR, DATA, RESP}
  - Owner enum `mem_arb_owner_t` {owner_fetch, owner_data}
  - Existing `XLEN` and `write_width_t`
- One natural sub-module, `mem_arb_select`: combinational grant logic from the req pair and `last_grant`. It is where `MEM_ARB_ROUND_ROBIN_EN` is applied.

## Test plan
- Fetch alone, `fetch_addr`=0x0006 with ROM word 0x00500093 at 0x0004 → `mem_addr`=0x0004 in N+1 and N+2; `fetch_rvalid`=1 with `fetch_rdata`=0x00500093 in N+3 only.
- Store word 0xDEADBEEF to 0x0800, then load 0x0800 → `mem_wenable` high exactly one cycle (N+1); store `data_rvalid` at N+3 with rdata 0; load returns 0xDEADBEEF.
- Fetch and data requests both held continuously → round-robin build: grants alternate fetch, data, fetch… every 4 cycles; fixed build: data is granted on every acceptance.
- Store byte 0x5A to 0x1800 → `mem_wwidth`=`write_byte`, `mem_addr`=0x1800, `mem_wdata`=0x5A during ADDR.
- Reset pulsed during ADDR of a store → `mem_wenable` falls in the same cycle; no `data_rvalid`; FSM is in IDLE and all outputs are at reset values after release.
- `data_req` raised in cycle N+2 of a fetch access → `data_ready` not asserted until cycle N+4; no req is lost or double-serviced.
